// File: rtl/mem_write_checker_pkg.sv
// Shared types for the CPU data-memory write checker: width aliases,
// failure cause codes, FSM states and a saturating counter helper.
package chk_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef enum logic [2:0] {
    FAIL_NONE          = 3'd0,
    FAIL_BAD_ADDR      = 3'd1,
    FAIL_DATA_MISMATCH = 3'd2,
    FAIL_ORDER         = 3'd3,
    FAIL_TIMEOUT       = 3'd4
  } chk_fail_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  localparam u32 CNT_MAX = 32'hFFFF_FFFF;

  function automatic u32 sat_inc(input u32 v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// CPU data-memory write port as seen by the checker. The CPU side drives it
// (master); the checker only observes it (slave). There is no back-pressure.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memwrite;
  logic [ADDR_W-1:0] dataaddr;
  logic [DATA_W-1:0] writedata;

  modport master (output memwrite, dataaddr, writedata);
  modport slave  (input  memwrite, dataaddr, writedata);
endinterface

// File: rtl/mem_write_checker_entry_match.sv
// Combinational comparison of one write against every checkpoint entry.
// Entry i lives at bits [i*W +: W] of the packed expectation vectors.
module chk_entry_match #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_CHECK = 2
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         data,
  input  logic [N_CHECK*ADDR_W-1:0] exp_addr,
  input  logic [N_CHECK*DATA_W-1:0] exp_data,
  output logic [N_CHECK-1:0]        addr_hit,
  output logic [N_CHECK-1:0]        full_hit
);

  always_comb begin
    addr_hit = '0;
    full_hit = '0;
    for (int i = 0; i < N_CHECK; i++) begin
      addr_hit[i] = (exp_addr[i*ADDR_W +: ADDR_W] == addr);
      full_hit[i] = addr_hit[i] && (exp_data[i*DATA_W +: DATA_W] == data);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Registered monitor that checks CPU data-memory writes against a table of
// expected (address, data) checkpoints and reports milestone/pass/fail/timeout.
module mem_write_checker
  import chk_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_CHECK = 2,
  parameter int TIMEOUT = 90,
  parameter int ORDERED = 1
) (
  input  u1                              clk,
  input  u1                              reset,
  input  u1                              start,
  input  u1                              clear,
  mem_write_checker_if.slave             wr,
  input  logic [N_CHECK*ADDR_W-1:0]      exp_addr,
  input  logic [N_CHECK*DATA_W-1:0]      exp_data,
  output u1                              milestone,
  output logic [N_CHECK-1:0]             hit_mask,
  output u1                              done,
  output u1                              pass,
  output u1                              fail,
  output chk_fail_e                      fail_code,
  output u32                             cycle_cnt,
  output logic [$clog2(N_CHECK+1)-1:0]   hit_count,
  output chk_state_e                     state
);

  localparam u32 TO_LAST = u32'(TIMEOUT - 1);

  chk_state_e         state_q, state_d;
  logic [N_CHECK-1:0] hit_d;
  u1                  ms_d;
  chk_fail_e          code_d;
  chk_fail_e          wr_code;
  u32                 cnt_d;

  logic [N_CHECK-1:0] addr_hit, full_hit;
  logic [N_CHECK-1:0] unhit, lowest_unhit;

  chk_entry_match #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .N_CHECK (N_CHECK)
  ) u_match (
    .addr     (wr.dataaddr),
    .data     (wr.writedata),
    .exp_addr (exp_addr),
    .exp_data (exp_data),
    .addr_hit (addr_hit),
    .full_hit (full_hit)
  );

  // One-hot of the lowest entry not yet hit; the only legal next hit when ordered.
  assign unhit        = ~hit_mask;
  assign lowest_unhit = unhit & (~unhit + N_CHECK'(1));

  always_comb begin
    state_d = state_q;
    hit_d   = hit_mask;
    ms_d    = 1'b0;
    code_d  = fail_code;
    cnt_d   = cycle_cnt;
    wr_code = FAIL_NONE;
    if (clear) begin
      state_d = ST_RUN;
      hit_d   = '0;
      code_d  = FAIL_NONE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          cnt_d = sat_inc(cycle_cnt);
          if (wr.memwrite) begin
            if (addr_hit == '0) begin
              wr_code = FAIL_BAD_ADDR;
            end else if (full_hit == '0) begin
              wr_code = FAIL_DATA_MISMATCH;
            end else if ((full_hit & hit_mask) == '0) begin
              // Repeat writes to an already-hit entry fall through untouched.
              if ((ORDERED != 0) && ((full_hit & ~lowest_unhit) != '0)) begin
                wr_code = FAIL_ORDER;
              end else begin
                hit_d = hit_mask | full_hit;
                ms_d  = 1'b1;
              end
            end
          end
          // Completion beats a write failure, which beats timeout.
          if (&hit_d) begin
            state_d = ST_PASS;
          end else if (wr_code != FAIL_NONE) begin
            state_d = ST_FAIL;
            code_d  = wr_code;
          end else if (cycle_cnt == TO_LAST) begin
            state_d = ST_FAIL;
            code_d  = FAIL_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hit_mask  <= '0;
      milestone <= 1'b0;
      fail_code <= FAIL_NONE;
      cycle_cnt <= '0;
    end else begin
      state_q   <= state_d;
      hit_mask  <= hit_d;
      milestone <= ms_d;
      fail_code <= code_d;
      cycle_cnt <= cnt_d;
    end
  end

  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign done      = pass | fail;
  assign state     = state_q;
  assign hit_count = ($clog2(N_CHECK+1))'($countones(hit_mask));

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: an ordered/TIMEOUT=90 instance and an
// unordered/TIMEOUT=20 instance share one write bus and one reference model.
module tb_mem_write_checker;
  import chk_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic [N*AW-1:0] exp_addr;
  logic [N*DW-1:0] exp_data;

  mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [1:0]         ms_o, done_o, pass_o, fail_o;
  logic [1:0][N-1:0]  hit_o;
  logic [1:0][2:0]    code_o;
  logic [1:0][31:0]   cnt_o;
  logic [1:0][1:0]    hcnt_o;
  logic [1:0][1:0]    st_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .N_CHECK(N), .TIMEOUT(90), .ORDERED(1)) dut_ord (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .wr(bus.slave),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .milestone(ms_o[0]), .hit_mask(hit_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .fail(fail_o[0]), .fail_code(code_o[0]), .cycle_cnt(cnt_o[0]),
    .hit_count(hcnt_o[0]), .state(st_o[0])
  );

  mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .N_CHECK(N), .TIMEOUT(20), .ORDERED(0)) dut_any (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .wr(bus.slave),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .milestone(ms_o[1]), .hit_mask(hit_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .fail(fail_o[1]), .fail_code(code_o[1]), .cycle_cnt(cnt_o[1]),
    .hit_count(hcnt_o[1]), .state(st_o[1])
  );

  // Reference model: 0 idle, 1 running, 2 passed, 3 failed.
  int          m_mode[2];
  bit          m_hit[2][N];
  int unsigned m_cnt[2];
  int          m_code[2];
  bit          m_ms[2];
  int          ordered_p[2] = '{1, 0};
  int          tout_p[2]    = '{90, 20};
  int unsigned ea[N]        = '{80, 84};
  int unsigned ed[N]        = '{7, 7};

  typedef struct {
    bit          st, cl, mw;
    int unsigned a, d;
    logic [1:0]  hit;
    bit          ms, ps, fl;
    logic [2:0]  code;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_code[k] = 0; m_ms[k] = 0;
      for (int i = 0; i < N; i++) m_hit[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit st, input bit cl, input bit mw,
                            input int unsigned a, input int unsigned d);
    int j, low, wcode;
    int unsigned cnt_at;
    bit all;
    m_ms[k] = 0;
    if (cl) begin
      m_mode[k] = 1; m_cnt[k] = 0; m_code[k] = 0;
      for (int i = 0; i < N; i++) m_hit[k][i] = 0;
      return;
    end
    if (m_mode[k] == 0) begin
      if (st) m_mode[k] = 1;
      return;
    end
    if (m_mode[k] != 1) return;
    j = -1; low = -1; wcode = 0;
    for (int i = 0; i < N; i++) begin
      if (a == ea[i]) j = i;
      if (!m_hit[k][i] && low < 0) low = i;
    end
    if (mw) begin
      if (j < 0) wcode = 1;
      else if (d != ed[j]) wcode = 2;
      else if (!m_hit[k][j]) begin
        if (ordered_p[k] != 0 && j != low) wcode = 3;
        else begin m_hit[k][j] = 1; m_ms[k] = 1; end
      end
    end
    cnt_at = m_cnt[k];
    if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k]++;
    all = 1;
    for (int i = 0; i < N; i++) if (!m_hit[k][i]) all = 0;
    if (all) m_mode[k] = 2;
    else if (wcode != 0) begin m_mode[k] = 3; m_code[k] = wcode; end
    else if (cnt_at == int'(tout_p[k] - 1)) begin m_mode[k] = 3; m_code[k] = 4; end
  endtask

  task automatic compare_model();
    logic [N-1:0] eh;
    int c;
    for (int k = 0; k < 2; k++) begin
      c = 0;
      for (int i = 0; i < N; i++) begin eh[i] = m_hit[k][i]; c += int'(m_hit[k][i]); end
      chk($sformatf("hit_mask[%0d]", k),  32'(hit_o[k]),  32'(eh));
      chk($sformatf("milestone[%0d]", k), 32'(ms_o[k]),   32'(m_ms[k]));
      chk($sformatf("pass[%0d]", k),      32'(pass_o[k]), 32'(m_mode[k] == 2));
      chk($sformatf("fail[%0d]", k),      32'(fail_o[k]), 32'(m_mode[k] == 3));
      chk($sformatf("done[%0d]", k),      32'(done_o[k]), 32'(m_mode[k] >= 2));
      chk($sformatf("fail_code[%0d]", k), 32'(code_o[k]), 32'(m_code[k]));
      chk($sformatf("cycle_cnt[%0d]", k), cnt_o[k],       m_cnt[k]);
      chk($sformatf("hit_count[%0d]", k), 32'(hcnt_o[k]), 32'(c));
    end
  endtask

  task automatic step(input bit st, input bit cl, input bit mw,
                      input int unsigned a, input int unsigned d);
    start = st; clear = cl; bus.memwrite = mw; bus.dataaddr = a; bus.writedata = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, st, cl, mw, a, d);
    #1;
    compare_model();
    start = 1'b0; clear = 1'b0; bus.memwrite = 1'b0;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_addr = {32'd84, 32'd80};
    exp_data = {32'd7, 32'd7};
    bus.memwrite = 1'b0; bus.dataaddr = '0; bus.writedata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    reset = 1'b1;

    //        st cl mw  a   d  hit ms ps fl code
    tbl[0]  = '{0, 0, 1, 80, 7, 2'b00, 0, 0, 0, 3'd0};
    tbl[1]  = '{1, 0, 0,  0, 0, 2'b00, 0, 0, 0, 3'd0};
    tbl[2]  = '{0, 0, 1, 80, 7, 2'b01, 1, 0, 0, 3'd0};
    tbl[3]  = '{0, 0, 0,  0, 0, 2'b01, 0, 0, 0, 3'd0};
    tbl[4]  = '{0, 0, 1, 80, 7, 2'b01, 0, 0, 0, 3'd0};
    tbl[5]  = '{0, 0, 1, 84, 7, 2'b11, 1, 1, 0, 3'd0};
    tbl[6]  = '{0, 0, 1, 84, 9, 2'b11, 0, 1, 0, 3'd0};
    tbl[7]  = '{0, 1, 1, 88, 3, 2'b00, 0, 0, 0, 3'd0};
    tbl[8]  = '{0, 0, 1, 80, 7, 2'b01, 1, 0, 0, 3'd0};
    tbl[9]  = '{0, 0, 1, 88, 3, 2'b01, 0, 0, 1, 3'd1};
    tbl[10] = '{0, 0, 1, 84, 7, 2'b01, 0, 0, 1, 3'd1};
    tbl[11] = '{0, 1, 1, 80, 7, 2'b00, 0, 0, 0, 3'd0};
    tbl[12] = '{0, 0, 1, 80, 5, 2'b00, 0, 0, 1, 3'd2};
    tbl[13] = '{0, 1, 0,  0, 0, 2'b00, 0, 0, 0, 3'd0};
    tbl[14] = '{0, 0, 1, 84, 7, 2'b00, 0, 0, 1, 3'd3};
    tbl[15] = '{1, 0, 0,  0, 0, 2'b00, 0, 0, 1, 3'd3};
    tbl[16] = '{0, 1, 0,  0, 0, 2'b00, 0, 0, 0, 3'd0};
    tbl[17] = '{0, 0, 1, 80, 7, 2'b01, 1, 0, 0, 3'd0};
    tbl[18] = '{0, 0, 1, 84, 7, 2'b11, 1, 1, 0, 3'd0};

    for (int r = 0; r < 19; r++) begin
      step(tbl[r].st, tbl[r].cl, tbl[r].mw, tbl[r].a, tbl[r].d);
      chk($sformatf("tbl%0d hit", r),  32'(hit_o[0]),  32'(tbl[r].hit));
      chk($sformatf("tbl%0d ms", r),   32'(ms_o[0]),   32'(tbl[r].ms));
      chk($sformatf("tbl%0d pass", r), 32'(pass_o[0]), 32'(tbl[r].ps));
      chk($sformatf("tbl%0d fail", r), 32'(fail_o[0]), 32'(tbl[r].fl));
      chk($sformatf("tbl%0d done", r), 32'(done_o[0]), 32'(tbl[r].ps | tbl[r].fl));
      chk($sformatf("tbl%0d code", r), 32'(code_o[0]), 32'(tbl[r].code));
    end

    // Timeout with no writes on the TIMEOUT=20 instance.
    step(0, 1, 0, 0, 0);
    nops(19);
    chk("to_pre fail", 32'(fail_o[1]), 32'd0);
    chk("to_pre cnt", cnt_o[1], 32'd19);
    nops(1);
    chk("to fail", 32'(fail_o[1]), 32'd1);
    chk("to code", 32'(code_o[1]), 32'd4);
    chk("to ord still running", 32'(done_o[0]), 32'd0);

    // Completing write exactly at the last allowed cycle wins over timeout.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 80, 7);
    nops(18);
    chk("edge cnt", cnt_o[1], 32'd19);
    step(0, 0, 1, 84, 7);
    chk("edge pass", 32'(pass_o[1]), 32'd1);
    chk("edge code", 32'(code_o[1]), 32'd0);

    // Failing write at the last allowed cycle reports the write's cause.
    step(0, 1, 0, 0, 0);
    nops(19);
    step(0, 0, 1, 88, 3);
    chk("edge bad code", 32'(code_o[1]), 32'd1);

    // Asynchronous reset mid-run right after a hit.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 80, 7);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst ms[%0d]", k),    32'(ms_o[k]),   32'd0);
      chk($sformatf("arst hit[%0d]", k),   32'(hit_o[k]),  32'd0);
      chk($sformatf("arst done[%0d]", k),  32'(done_o[k]), 32'd0);
      chk($sformatf("arst pass[%0d]", k),  32'(pass_o[k]), 32'd0);
      chk($sformatf("arst fail[%0d]", k),  32'(fail_o[k]), 32'd0);
      chk($sformatf("arst code[%0d]", k),  32'(code_o[k]), 32'd0);
      chk($sformatf("arst cnt[%0d]", k),   cnt_o[k],       32'd0);
      chk($sformatf("arst state[%0d]", k), 32'(st_o[k]),   32'(ST_IDLE));
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bit st, cl, mw;
      int unsigned a, d, r;
      st = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 39) == 0);
      mw = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 9);
      a  = (r < 4) ? 32'd80 : (r < 8) ? 32'd84 : (r == 8) ? 32'd88 : $urandom;
      d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 32'd7;
      step(st, cl, mw, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Self-checking monitor for the multicycle CPU bench. It watches the CPU data-memory write port (`memwrite`, `dataaddr`, `writedata`) and compares every write against a table of N expected (address, data) checkpoints. It reports milestones, pass, fail with a cause code, and timeout. It replaces ad-hoc per-program `always` checks with one parametrised, registered checker that a bench instantiates next to `cpu`.

## Interface

Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `N_CHECK`, 2: number of checkpoints, ≥1.
- `TIMEOUT`, 90: cycles allowed in RUN before timeout fail, ≥1.
- `ORDERED`, 1: 1 means checkpoints must be hit in index order; 0 means any order.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  one-cycle pulse; IDLE → RUN.
- `clear`  in  1  synchronous restart; any state → RUN with counters zeroed.
- `memwrite`  in  1  CPU write strobe.
- `dataaddr`  in  ADDR_W  CPU write address.
- `writedata`  in  DATA_W  CPU write data.
- `exp_addr`  in  N_CHECK×ADDR_W  expected addresses; stable while in RUN; entries distinct.
- `exp_data`  in  N_CHECK×DATA_W  expected data.
- `milestone`  out  1  one-cycle pulse per newly hit checkpoint.
- `hit_mask`  out  N_CHECK  checkpoints hit so far.
- `done`  out  1  in PASS or FAIL.
- `pass`  out  1  in PASS.
- `fail`  out  1  in FAIL.
- `fail_code`  out  3  cause, type `chk_fail_e`.
- `cycle_cnt`  out  32  cycles spent in RUN; saturates.

## Operation

- States: IDLE, RUN, PASS, FAIL.
  - Reset → IDLE.
  - IDLE + `start` → RUN.
  - `clear` has priority over everything except reset; it applies from any state and enters RUN.
  - PASS and FAIL are sticky until `clear` or reset.
- Writes are evaluated only in RUN when `memwrite` = 1. Per write, with `idx` = the lowest unhit entry:
  - Address matches no entry → FAIL, code BAD_ADDR (1).
  - Address matches entry j but data differs → FAIL, code DATA_MISMATCH (2).
  - ORDERED = 1, address and data match entry j but j ≠ idx:
    - if j is already hit, the write is ignored (repeat write);
    - otherwise → FAIL, code ORDER (3).
  - Otherwise, full match on an unhit entry → set `hit_mask[j]`, pulse `milestone`.
  - Full match on an already-hit entry → ignored; no pulse.
  - All bits of `hit_mask` set after the update → PASS.
- Timeout: in RUN, if `cycle_cnt` = TIMEOUT−1 and the cycle does not complete the table → FAIL, code TIMEOUT (4).
  - A completing write on that same cycle → PASS (completion wins).
  - A failing write on that same cycle → that write's code (write causes win over TIMEOUT).
- `cycle_cnt` increments every RUN cycle and saturates at 2^32−1.
- Checkpoint count: `$countones(hit_mask)`, width `$clog2(N_CHECK+1)`.

## Timing

- All outputs are registered. A write sampled at edge k is reflected in `hit_mask`, `milestone`, `pass`, `fail`, and `fail_code` after edge k, with no combinational path from inputs to outputs.
- `milestone` is high for exactly one cycle per new hit.
- Reset values (asynchronous, on `reset` = 0): state IDLE, `milestone` 0, `hit_mask` 0, `done` 0, `pass` 0, `fail` 0, `fail_code` NONE (0), `cycle_cnt` 0.
- Reset asserted mid-RUN: all outputs go to their reset values immediately, not at the next edge.
- `clear` sampled at edge k: after the edge, state is RUN, `hit_mask` = 0, `cycle_cnt` = 0, `fail_code` = 0. A write in the same cycle as `clear` is discarded.
- `start` outside IDLE is ignored. Writes in IDLE, PASS, or FAIL are ignored.

## Structure

- Shared package `chk_pkg`:
  - `chk_fail_e` (3-bit enum: NONE, BAD_ADDR, DATA_MISMATCH, ORDER, TIMEOUT);
  - `chk_state_e`.
- Widths use the existing `u1`/`u32` typedefs from `common.svh`.
- One sub-module, `chk_entry_match`: purely combinational, N_CHECK-wide.
  - Outputs `addr_hit[N]` and `full_hit[N]` vectors.
  - The top-level FSM, counters, and priority logic use these vectors.

## Test plan

Defaults unless stated: N_CHECK = 2, `exp_addr` = {80, 84}, `exp_data` = {7, 7}, TIMEOUT = 90.

1. `start`, then (80,7) at RUN cycle 5 and (84,7) at cycle 9 → `milestone` pulses after each write; `hit_mask` = 2'b11, `pass` = 1, `done` = 1 after the cycle-9 edge; `fail_code` = 0.
2. (80,7), then (88,3) → `fail` = 1, `fail_code` = 1. A later (84,7) changes nothing.
3. (80,5) → `fail_code` = 2, `hit_mask` = 0. Separately, (80,7) twice then (84,7) → one `milestone` for 80 and PASS.
4. ORDERED = 1: (84,7) first → `fail_code` = 3. ORDERED = 0: (84,7) then (80,7) → PASS.
5. TIMEOUT = 20, no writes → FAIL with `fail_code` = 4 after the edge at `cycle_cnt` = 19. Re-run with (80,7) earlier and (84,7) exactly at `cycle_cnt` = 19 → PASS.
6. `reset` = 0 mid-RUN after one hit → outputs zero immediately, state IDLE. Separately, `clear` in FAIL → RUN with `hit_mask` = 0; a write in the same cycle as `clear` is discarded.
